// File: rtl/pulse_period_checker.sv
// Measures the spacing between strobe events, compares it with an expected period,
// and reports lock, mismatch and timeout status as registered outputs.
module pulse_period_checker #(
    parameter int unsigned W          = 8,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         pulse_in,
    input  logic [W-1:0] exp_period,
    output logic [W-1:0] period,
    output logic         period_valid,
    output logic         locked,
    output logic         mismatch,
    output logic         timeout
);

    localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0] LAST_M = MW'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {IDLE, MEAS, LOCKED} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [MW-1:0]  match_q, match_d;
    logic [W-1:0]   period_q, period_d;
    logic           pv_d, mm_d, to_d;
    logic           pv_q, locked_q, mm_q, to_q;
    logic           ev;

    assign ev = en & pulse_in;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        match_d  = match_q;
        period_d = period_q;
        pv_d     = 1'b0;
        mm_d     = 1'b0;
        to_d     = 1'b0;
        // A zero expected period parks the block in IDLE just like en=0.
        if (!en || exp_period == '0) begin
            state_d = IDLE;
            cnt_d   = '0;
            match_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (ev) begin
                        state_d = MEAS;
                        cnt_d   = W'(1);
                        match_d = '0;
                    end
                end
                MEAS, LOCKED: begin
                    if (ev) begin
                        cnt_d    = W'(1);
                        period_d = cnt_q;
                        pv_d     = 1'b1;
                        if (cnt_q == exp_period) begin
                            if (state_q == MEAS) begin
                                match_d = match_q + 1'b1;
                                if (match_q == LAST_M) begin
                                    state_d = LOCKED;
                                end
                            end
                        end else begin
                            mm_d    = 1'b1;
                            match_d = '0;
                            state_d = MEAS;
                        end
                    end else if (cnt_q == exp_period) begin
                        to_d    = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                        match_d = '0;
                    end else begin
                        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    match_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            match_q  <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            locked_q <= 1'b0;
            mm_q     <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            match_q  <= match_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            locked_q <= (state_d == LOCKED);
            mm_q     <= mm_d;
            to_q     <= to_d;
        end
    end

    assign period       = period_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign mismatch     = mm_q;
    assign timeout      = to_q;

endmodule

// File: tb/tb_pulse_period_checker.sv
// Directed bench for pulse_period_checker (W=8, LOCK_COUNT=4) with hand-derived
// expectations; each step drives pulse_in for one edge and samples 1 ns later.
module tb_pulse_period_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       pulse_in;
    logic [7:0] exp_period;
    logic [7:0] period;
    logic       period_valid;
    logic       locked;
    logic       mismatch;
    logic       timeout;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    pulse_period_checker #(.W(8), .LOCK_COUNT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .pulse_in     (pulse_in),
        .exp_period   (exp_period),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .mismatch     (mismatch),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Packed as {period, period_valid, locked, mismatch, timeout}.
    task automatic chk(input string tag, input logic [7:0] p, input logic pv,
                       input logic lk, input logic mm, input logic to);
        check_eq(tag, {20'd0, period, period_valid, locked, mismatch, timeout},
                 {20'd0, p, pv, lk, mm, to});
    endtask

    task automatic step(input logic p);
        pulse_in = p;
        @(posedge clk);
        #1;
    endtask

    // From IDLE with exp_period=3: first event, then four matching periods of 3.
    task automatic acquire(input string tag);
        step(1'b1);
        check_eq({tag, "_first_pv"}, {31'd0, period_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            step(1'b0);
            check_eq({tag, "_gap_pv"}, {31'd0, period_valid}, 32'd0);
            step(1'b1);
            chk({tag, "_match"}, 8'd3, 1'b1, (i == 3), 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [15:0] pat;
        reset      = 1'b1;
        en         = 1'b0;
        pulse_in   = 1'b0;
        exp_period = 8'd3;
        step(1'b1);
        step(1'b1);
        chk("reset_state", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        reset = 1'b0;
        en    = 1'b1;
        acquire("acq");
        step(1'b0);
        step(1'b0);
        step(1'b1);
        chk("stay_locked", 8'd3, 1'b1, 1'b1, 1'b0, 1'b0);

        step(1'b0);
        step(1'b1);
        chk("early_mismatch", 8'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0);
        chk("mismatch_one_cycle", 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);

        en = 1'b0;
        step(1'b0);
        en = 1'b1;
        acquire("acq2");
        step(1'b0);
        chk("wait1", 8'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0);
        chk("wait2", 8'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0);
        chk("timeout", 8'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0);
        chk("timeout_one_cycle", 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1);
        chk("restart_no_pv", 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        chk("restart_period", 8'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0);
        chk("restart_single_pv", 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        en = 1'b0;
        step(1'b0);
        en = 1'b1;
        acquire("acq3");
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            chk("en_low_hold", 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        en = 1'b1;
        acquire("acq4");
        step(1'b0);
        step(1'b0);
        reset = 1'b1;
        step(1'b1);
        chk("reset_in_locked", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        en         = 1'b0;
        exp_period = 8'd1;
        step(1'b0);
        en = 1'b1;
        step(1'b1);
        chk("p1_first", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 2; i <= 6; i++) begin
            step(1'b1);
            chk("p1_steady", 8'd1, 1'b1, (i >= 5), 1'b0, 1'b0);
        end

        reset      = 1'b1;
        en         = 1'b0;
        exp_period = 8'd0;
        step(1'b0);
        reset = 1'b0;
        en    = 1'b1;
        pat   = 16'hB3A5;
        for (int i = 0; i < 16; i++) begin
            step(pat[i]);
            chk("exp_zero_idle", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_period_checker.md
PULSE_PERIOD_CHECKER -- requirements
Module: pulse_period_checker

Interface
REQ-001 Parameter W, default 8: width of the cycle counter, exp_period and period.
REQ-002 Parameter LOCK_COUNT, default 4: consecutive matching periods required to assert locked; legal range is LOCK_COUNT >= 1.
REQ-003 clk  input  1  single clock; all logic is on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  enable; when 0 the block is held idle.
REQ-006 pulse_in  input  1  strobe under test; each cycle sampled high is one event.
REQ-007 exp_period  input  W  expected event spacing in cycles; the source must change it only while en=0.
REQ-008 period  output  W  last measured event spacing in cycles.
REQ-009 period_valid  output  1  one-cycle pulse indicating that period has been updated.
REQ-010 locked  output  1  level signal; the strobe has matched exp_period LOCK_COUNT times in a row.
REQ-011 mismatch  output  1  one-cycle pulse for a measured period not equal to exp_period.
REQ-012 timeout  output  1  one-cycle pulse for an expected event that did not arrive.

Function
REQ-013 The block shall have states IDLE, MEAS and LOCKED; all outputs shall be registered.
REQ-014 Event: shall be a cycle with en=1 and pulse_in=1, with no edge detection; a constantly high pulse_in gives period 1.
REQ-015 Counter cnt: shall load 1 on an event; otherwise, in MEAS or LOCKED, it shall increment, saturating at 2^W-1; in IDLE it shall hold 0.
REQ-016 Measured period: shall be the cnt value on the event cycle, before the update (events 3 cycles apart give 3).
REQ-017 IDLE: an event shall move the block to MEAS with match_cnt=0; no period_valid is issued for this first event.
REQ-018 MEAS/LOCKED event: period shall be set to cnt, with period_valid=1 on the next cycle.
REQ-019 MEAS, cnt==exp_period: match_cnt shall increment; on reaching LOCK_COUNT the block shall go to LOCKED, and locked shall be 1 from the next cycle.
REQ-020 MEAS, cnt!=exp_period (early event): mismatch shall pulse, match_cnt shall be 0, and the block shall stay in MEAS.
REQ-021 LOCKED, cnt!=exp_period (early event): mismatch shall pulse, locked shall drop next cycle, the block shall go to MEAS, and match_cnt shall be 0.
REQ-022 Missing event: in MEAS/LOCKED with cnt==exp_period and pulse_in=0, timeout shall pulse, locked shall drop, and the block shall go to IDLE; the next event restarts acquisition.
REQ-023 An event on the cycle where cnt==exp_period is a match, never a timeout.
REQ-024 mismatch and timeout shall be mutually exclusive per cycle; each pulse lasts exactly one cycle.
REQ-025 exp_period==0: the block shall stay in IDLE permanently, with no pulses and locked=0.
REQ-026 en=0: the next state shall be IDLE with cnt=0, match_cnt=0 and locked=0; pulse_in is ignored; period holds its value.
REQ-027 Priority: reset > en=0 > event/timeout evaluation.
REQ-028 match_cnt width shall be clog2(LOCK_COUNT+1) bits, and it shall never exceed LOCK_COUNT.

Reset
REQ-029 While reset=1 at a clock edge: state=IDLE, cnt=0, match_cnt=0, period=0, period_valid=0, locked=0, mismatch=0, timeout=0.
REQ-030 Reset asserted mid-operation, including in LOCKED, shall take effect at that clock edge; any pulse due on that cycle shall be suppressed.

Verification
REQ-031 exp_period=3, events at t, t+3, t+6, t+9, t+12 -> period_valid at t+4, t+7, t+10, t+13 with period=3; locked=1 from t+13.
REQ-032 Locked at period 3, next event arrives 2 cycles after the previous one -> one cycle later period=2, period_valid=1, mismatch=1; locked=0 on that same cycle.
REQ-033 Locked at period 3, pulse_in held 0 -> timeout=1 and locked=0 the cycle after cnt reaches 3; the block is then IDLE, and the next two events 3 apart give a single period_valid with period=3.
REQ-034 pulse_in held at 1 with exp_period=1, LOCK_COUNT=4 -> period=1 every cycle; locked=1 after the fifth high cycle.
REQ-035 reset or en=0 asserted while locked -> all outputs follow REQ-029 (period held for en=0); pulses during en=0 produce no response.
REQ-036 exp_period=0 with arbitrary pulse_in -> all outputs remain 0.
